clk_period_meter: RTL
=====================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CntWidth, 26, width of all period/high-time counters and outputs.
REQ-002 Parameter TimeoutVal, 60000000, Clk cycles without a rising edge before Timeout is flagged; SHALL be < 2^CntWidth.
REQ-003 Clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Rst  input  1  synchronous, active-low reset; SHALL be sampled on rising Clk.
REQ-005 SigIn  input  1  slow signal to measure (e.g. a divided clock); SHALL be treated as asynchronous to Clk.
REQ-006 Clear  input  1  synchronous clear of the sticky Timeout flag and the measurement state.
REQ-007 Period  output  CntWidth  last measured rising-to-rising interval of SigIn, in Clk cycles.
REQ-008 HighTime  output  CntWidth  Clk cycles SigIn was high within the last measured period.
REQ-009 Valid  output  1  single-cycle pulse; Period/HighTime updated this cycle.
REQ-010 Timeout  output  1  sticky flag; no rising edge for TimeoutVal cycles.

Function
REQ-011 SigIn SHALL pass through a two-flop synchronizer (S1, S2); a third flop S3 SHALL hold the previous S2.
REQ-012 Rise SHALL be S2 & ~S3; detection latency SHALL be 3 Clk cycles from the SigIn transition.
REQ-013 The FSM SHALL have two states: IDLE (wait for first Rise) and MEASURE.
REQ-014 IDLE: on Rise -> MEASURE, PerCnt <= 0, HighCnt <= 1; Valid SHALL NOT assert.
REQ-015 MEASURE, no Rise: PerCnt <= PerCnt+1; HighCnt <= HighCnt+1 when S2=1, otherwise hold.
REQ-016 MEASURE, Rise: Period <= PerCnt+1, HighTime <= HighCnt, Valid <= 1 for exactly one cycle, PerCnt <= 0, HighCnt <= 1; stay in MEASURE.
REQ-017 Timeout check: when PerCnt reaches TimeoutVal-1 in MEASURE without a Rise, Timeout <= 1 and the FSM SHALL return to IDLE.
REQ-018 On a timeout, Period and HighTime SHALL hold their last values and Valid SHALL NOT pulse.
REQ-019 Timeout SHALL stay high until Rst or Clear; a later Rise SHALL NOT clear it.
REQ-020 Rise and timeout in the same cycle: Rise SHALL win (a measurement is taken and Timeout is not set).
REQ-021 Clear=1: FSM -> IDLE, Timeout <= 0, PerCnt <= 0, HighCnt <= 0, Valid <= 0; Period and HighTime SHALL hold.
REQ-022 Clear coincident with Rise: Clear SHALL win; the next Rise SHALL be treated as the first edge.
REQ-023 All counter arithmetic SHALL be unsigned CntWidth bits; REQ-017 SHALL guarantee PerCnt never wraps.
REQ-024 A constant SigIn (stuck high or stuck low) SHALL produce Timeout, and SHALL NOT produce Valid.

Reset
REQ-025 Rst=0 at a Clk edge: FSM=IDLE; PerCnt, HighCnt, Period and HighTime = 0; Valid=0; Timeout=0; S1/S2/S3 = 0.
REQ-026 Rst SHALL have priority over Clear and Rise.
REQ-027 Rst asserted mid-measurement SHALL discard the partial count; the first Rise after release SHALL NOT produce Valid.
REQ-028 S1/S2/S3 reset to 0: SigIn high at reset release SHALL be detected as a Rise 3 cycles later, and this Rise SHALL only arm MEASURE.

Verification
REQ-029 Scenario: SigIn square wave, 2 cycles high / 2 cycles low -> from the second Rise on, Valid pulses every 4 cycles with Period=4, HighTime=2.
REQ-030 Scenario: SigIn 3 high / 7 low, steady -> Period=10, HighTime=3 on every Valid; Timeout=0.
REQ-031 Scenario: TimeoutVal=20; one Rise, then SigIn held low -> Timeout=1 exactly 20 cycles after the Rise entered MEASURE; Period unchanged; no Valid.
REQ-032 Scenario: Timeout=1, then Clear pulse, then a 4-cycle square wave -> Timeout=0 after Clear; the first Valid comes on the second Rise after Clear, with Period=4.
REQ-033 Scenario: Rst=0 for 1 cycle mid-period of a 10-cycle wave -> all outputs 0 next cycle; the first Valid after release comes on the second Rise, with Period=10.
REQ-034 Scenario: TimeoutVal=10, SigIn period exactly 10 (Rise coincides with the timeout cycle) -> Valid with Period=10; Timeout stays 0.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the rising-edge period and high time of a slow asynchronous input in Clk cycles,
// raising a sticky Timeout when the input stops producing rising edges.
module clk_period_meter #(
  parameter int CntWidth   = 26,
  parameter int TimeoutVal = 60000000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                SigIn,
  input  logic                Clear,
  output logic [CntWidth-1:0] Period,
  output logic [CntWidth-1:0] HighTime,
  output logic                Valid,
  output logic                Timeout
);

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutVal - 1);
  localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);

  typedef enum logic {
    Idle,
    Measure
  } stateT;

  stateT               state;
  logic                s1;
  logic                s2;
  logic                s3;
  logic                rise;
  logic [CntWidth-1:0] perCnt;
  logic [CntWidth-1:0] highCnt;

  // s1/s2 resynchronise SigIn; s3 is only the edge-detect history.
  assign rise = s2 & ~s3;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= Idle;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      perCnt   <= '0;
      highCnt  <= '0;
      Period   <= '0;
      HighTime <= '0;
      Valid    <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      s1    <= SigIn;
      s2    <= s1;
      s3    <= s2;
      Valid <= 1'b0;
      if (Clear) begin
        state   <= Idle;
        Timeout <= 1'b0;
        perCnt  <= '0;
        highCnt <= '0;
      end else begin
        case (state)
          Idle: begin
            if (rise) begin
              state   <= Measure;
              perCnt  <= '0;
              highCnt <= CntOne;
            end
          end
          Measure: begin
            // A rise in the timeout cycle still closes the period normally.
            if (rise) begin
              Period   <= perCnt + CntOne;
              HighTime <= highCnt;
              Valid    <= 1'b1;
              perCnt   <= '0;
              highCnt  <= CntOne;
            end else if (perCnt == TimeoutLast) begin
              Timeout <= 1'b1;
              state   <= Idle;
            end else begin
              perCnt <= perCnt + CntOne;
              if (s2) begin
                highCnt <= highCnt + CntOne;
              end
            end
          end
          default: state <= Idle;
        endcase
      end
    end
  end

endmodule
